// File: rtl/cam_stream_if.sv
// Camera pixel bus: frame sync, line valid and pixel byte, as seen on the
// OV7670-style parallel interface. The generator drives it through the master
// modport and a capture block receives it through the slave modport.
interface cam_stream_if;
    logic       CAM_vsync;
    logic       CAM_href;
    logic [7:0] CAM_px_data;

    modport master (output CAM_vsync, output CAM_href, output CAM_px_data);
    modport slave  (input  CAM_vsync, input  CAM_href, input  CAM_px_data);
endinterface

// File: rtl/cam_stream_gen.sv
// OV7670-style camera stream generator, QQVGA RGB444, two bytes per pixel.
// Frame: VSYNC -> VBP -> ACTIVE -> VFP, every interval a whole number of
// line periods. The next state and counters are decoded combinationally and
// every output is registered from them, so outputs line up with the state.
// Optional build macro: CAM_STREAM_FRAMECNT_EN -- a 12-bit frame counter
// replaces pixel (0,0) of each frame so captured frames can be told apart.
module cam_stream_gen #(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int H_BLANK      = 144,
    parameter int VSYNC_LINES  = 3,
    parameter int VBP_LINES    = 17,
    parameter int VFP_LINES    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pattern,
    input  logic [11:0] solid_color,
    cam_stream_if.master cam,
    output logic        frame_done,
    output logic        busy
);
    localparam int LINE_LEN = 2 * CAM_SCREEN_X + H_BLANK;
    localparam int MAX_V01  = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
    localparam int MAX_V23  = (CAM_SCREEN_Y > VFP_LINES) ? CAM_SCREEN_Y : VFP_LINES;
    localparam int MAX_V    = (MAX_V01 > MAX_V23) ? MAX_V01 : MAX_V23;
    localparam int BYTE_W   = $clog2(LINE_LEN);
    localparam int LINE_W   = (MAX_V > 1) ? $clog2(MAX_V) : 1;

    localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(LINE_LEN - 1);
    localparam logic [BYTE_W-1:0] ACT_BYTES  = BYTE_W'(2 * CAM_SCREEN_X);
    localparam logic [LINE_W-1:0] VSYNC_LAST = LINE_W'(VSYNC_LINES - 1);
    localparam logic [LINE_W-1:0] VBP_LAST   = LINE_W'(VBP_LINES - 1);
    localparam logic [LINE_W-1:0] ACT_LAST   = LINE_W'(CAM_SCREEN_Y - 1);
    localparam logic [LINE_W-1:0] VFP_LAST   = LINE_W'(VFP_LINES - 1);
    localparam logic [7:0]        BAR_W      = 8'(CAM_SCREEN_X / 8);

    localparam logic [11:0] BAR_RGB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_VBP    = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_VFP    = 3'd4;

    logic [2:0]        state_reg, state_next, after_state;
    logic [BYTE_W-1:0] byte_reg, byte_next;
    logic [LINE_W-1:0] line_reg, line_next, last_line;
    logic [1:0]        pat_reg;
    logic [11:0]       color_reg;
    logic              vsync_reg, href_reg, frame_done_reg, busy_reg;
    logic [7:0]        px_reg, px_next;
    logic              active_next, frame_end_next;
    logic [7:0]        x_next;
    logic [3:0]        y_hi;
    logic [2:0]        bar_idx;
    logic [11:0]       rgb;
`ifdef CAM_STREAM_FRAMECNT_EN
    logic [11:0]       frame_cnt_reg;
`endif

    // Length (in lines) of the current interval and the state that follows it.
    always_comb begin
        last_line   = '0;
        after_state = ST_IDLE;
        case (state_reg)
            ST_VSYNC:  begin last_line = VSYNC_LAST; after_state = ST_VBP;    end
            ST_VBP:    begin last_line = VBP_LAST;   after_state = ST_ACTIVE; end
            ST_ACTIVE: begin last_line = ACT_LAST;   after_state = ST_VFP;    end
            ST_VFP:    begin last_line = VFP_LAST;   after_state = en ? ST_VSYNC : ST_IDLE; end
            default:   ;
        endcase
    end

    // Next state and byte/line counters; en is only looked at in IDLE and at the end of VFP.
    always_comb begin
        state_next = state_reg;
        byte_next  = byte_reg;
        line_next  = line_reg;
        case (state_reg)
            ST_IDLE: begin
                byte_next = '0;
                line_next = '0;
                if (en) state_next = ST_VSYNC;
            end
            ST_VSYNC, ST_VBP, ST_ACTIVE, ST_VFP: begin
                if (byte_reg == BYTE_LAST) begin
                    byte_next = '0;
                    if (line_reg == last_line) begin
                        line_next  = '0;
                        state_next = after_state;
                    end else begin
                        line_next = line_reg + 1'b1;
                    end
                end else begin
                    byte_next = byte_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                byte_next  = '0;
                line_next  = '0;
            end
        endcase
    end

    assign x_next         = 8'(byte_next >> 1);
    assign y_hi           = 4'(line_next >> 3);
    assign bar_idx        = 3'(x_next / BAR_W);
    assign active_next    = (state_next == ST_ACTIVE) && (byte_next < ACT_BYTES);
    assign frame_end_next = (state_next == ST_VFP) && (byte_next == BYTE_LAST) &&
                            (line_next == VFP_LAST);

    // Colour of the pixel about to be driven, from the pattern latched at frame start.
    always_comb begin
        rgb = 12'h000;
        case (pat_reg)
            2'd0:    rgb = BAR_RGB[bar_idx];
            2'd1:    rgb = color_reg;
            2'd2:    rgb = {x_next[7:4], y_hi, 4'h8};
            default: rgb = (x_next[3] ^ y_hi[0]) ? 12'hFFF : 12'h000;
        endcase
`ifdef CAM_STREAM_FRAMECNT_EN
        if (x_next == 8'd0 && line_next == '0) rgb = frame_cnt_reg;
`endif
        px_next = 8'h00;
        if (active_next) px_next = byte_next[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
    end

    // State, counters and all registered outputs; pattern/colour latched on entry to VSYNC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            byte_reg       <= '0;
            line_reg       <= '0;
            pat_reg        <= 2'd0;
            color_reg      <= 12'h000;
            vsync_reg      <= 1'b0;
            href_reg       <= 1'b0;
            px_reg         <= 8'h00;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_reg       <= byte_next;
            line_reg       <= line_next;
            vsync_reg      <= (state_next == ST_VSYNC);
            href_reg       <= active_next;
            px_reg         <= px_next;
            frame_done_reg <= frame_end_next;
            busy_reg       <= (state_next != ST_IDLE);
            if (state_next == ST_VSYNC && state_reg != ST_VSYNC) begin
                pat_reg   <= pattern;
                color_reg <= solid_color;
            end
        end
    end

`ifdef CAM_STREAM_FRAMECNT_EN
    // Frame counter steps together with the frame_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              frame_cnt_reg <= 12'h000;
        else if (frame_end_next) frame_cnt_reg <= frame_cnt_reg + 12'h001;
    end
`endif

    assign cam.CAM_vsync   = vsync_reg;
    assign cam.CAM_href    = href_reg;
    assign cam.CAM_px_data = px_reg;
    assign frame_done      = frame_done_reg;
    assign busy            = busy_reg;
endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen: one default-size instance for the real
// QQVGA line/vsync timing and pixel bytes, one small instance for whole-frame
// behaviour (patterns, latching, back-to-back frames, en drop, reset).
module tb_cam_stream_gen;
    localparam int S_X = 32, S_Y = 16, S_H = 8, S_VS = 2, S_VBP = 3, S_VFP = 2;
    localparam int S_L = 2 * S_X + S_H;
    localparam int S_FRAME = (S_VS + S_VBP + S_Y + S_VFP) * S_L;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic d_rst_n, d_en, d_fd, d_busy;
    logic [1:0] d_pattern;
    logic [11:0] d_color;
    logic s_rst_n, s_en, s_fd, s_busy;
    logic [1:0] s_pattern;
    logic [11:0] s_color;

    cam_stream_if d_cam ();
    cam_stream_if s_cam ();

    cam_stream_gen dut_d (
        .clk(clk), .rst_n(d_rst_n), .en(d_en), .pattern(d_pattern), .solid_color(d_color),
        .cam(d_cam), .frame_done(d_fd), .busy(d_busy)
    );

    cam_stream_gen #(
        .CAM_SCREEN_X(S_X), .CAM_SCREEN_Y(S_Y), .H_BLANK(S_H),
        .VSYNC_LINES(S_VS), .VBP_LINES(S_VBP), .VFP_LINES(S_VFP)
    ) dut_s (
        .clk(clk), .rst_n(s_rst_n), .en(s_en), .pattern(s_pattern), .solid_color(s_color),
        .cam(s_cam), .frame_done(s_fd), .busy(s_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] fbuf [0:S_Y-1][0:2*S_X-1];
    logic [7:0] lb [0:319];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s got %0h", tag, got);
        end
    endtask

    task automatic check_px(input string tag, input int y, input int x, input logic [15:0] exp);
        check(tag, {16'h0, fbuf[y][2*x], fbuf[y][2*x+1]}, {16'h0, exp});
    endtask

    // Wait (bounded) until the small instance raises vsync.
    task automatic wait_s_vs(input string tag);
        int n = 0;
        while (!s_cam.CAM_vsync && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, s_cam.CAM_vsync, 1);
    endtask

    // Called on the first vsync cycle; runs to frame_done, storing the active bytes.
    task automatic capture_frame(input int chg_cycle, input logic [1:0] chg_pat,
                                 input int drop_cycle,
                                 output int len, output int lines, output int bad);
        int hi = 0, lo = 0, vs = 0;
        logic prev = 1'b0;
        len = 0; lines = 0; bad = 0;
        while (1) begin
            len++;
            if (len == chg_cycle)  s_pattern = chg_pat;
            if (len == drop_cycle) s_en = 1'b0;
            if (s_cam.CAM_vsync) vs++;
            if (!s_busy) bad++;
            if (s_cam.CAM_href) begin
                if (!prev) begin
                    if (lines > 0 && lo != S_H) bad++;
                    hi = 0;
                end
                if (lines < S_Y && hi < 2 * S_X) fbuf[lines][hi] = s_cam.CAM_px_data;
                hi++;
            end else begin
                if (prev) begin
                    if (hi != 2 * S_X) bad++;
                    lines++;
                    lo = 0;
                end
                lo++;
                if (s_cam.CAM_px_data != 8'h00) bad++;
            end
            prev = s_cam.CAM_href;
            if (s_fd || len >= 4000) break;
            @(negedge clk);
        end
        if (vs != S_VS * S_L) bad++;
    endtask

    initial begin
        int cnt, nz, len, lines, bad;
        d_rst_n = 0; d_en = 0; d_pattern = 2'd0; d_color = 12'h000;
        s_rst_n = 0; s_en = 0; s_pattern = 2'd1; s_color = 12'hA5C;
        repeat (3) @(negedge clk);

        // ---- default-size instance: reset, vsync/VBP/line timing, bar bytes ----
        check("d_rst_vsync", d_cam.CAM_vsync, 0);
        check("d_rst_href", d_cam.CAM_href, 0);
        check("d_rst_px", d_cam.CAM_px_data, 0);
        check("d_rst_fd", d_fd, 0);
        check("d_rst_busy", d_busy, 0);
        d_rst_n = 1;
        @(negedge clk);
        d_en = 1;
        @(negedge clk);
        check("d_start_vsync", d_cam.CAM_vsync, 1);
        check("d_start_busy", d_busy, 1);
        cnt = 0;
        while (d_cam.CAM_vsync && cnt < 3000) begin cnt++; @(negedge clk); end
        check("d_vsync_len", cnt, 1392);
        cnt = 0;
        while (!d_cam.CAM_href && cnt < 10000) begin cnt++; @(negedge clk); end
        check("d_vbp_len", cnt, 7888);
        cnt = 0;
        while (d_cam.CAM_href && cnt < 1000) begin
            if (cnt < 320) lb[cnt] = d_cam.CAM_px_data;
            cnt++;
            @(negedge clk);
        end
        check("d_href_len", cnt, 320);
`ifdef CAM_STREAM_FRAMECNT_EN
        check("d_px0", {lb[0], lb[1]}, 16'h0000);
`else
        check("d_px0", {lb[0], lb[1]}, 16'h0FFF);
`endif
        check("d_px20_yellow", {lb[40], lb[41]}, 16'h0FF0);
        check("d_px159_black", {lb[318], lb[319]}, 16'h0000);
        cnt = 0; nz = 0;
        while (!d_cam.CAM_href && cnt < 1000) begin
            if (d_cam.CAM_px_data != 8'h00) nz++;
            cnt++;
            @(negedge clk);
        end
        check("d_hblank_len", cnt, 144);
        check("d_hblank_px0", nz, 0);
        repeat (100) @(negedge clk);
        check("d_midline_href", d_cam.CAM_href, 1);
        d_rst_n = 0;
        #1;
        check("d_rst_mid_vsync", d_cam.CAM_vsync, 0);
        check("d_rst_mid_href", d_cam.CAM_href, 0);
        check("d_rst_mid_px", d_cam.CAM_px_data, 0);
        check("d_rst_mid_busy", d_busy, 0);
        d_en = 0;

        // ---- small instance: whole frames ----
        @(negedge clk);
        s_rst_n = 1;
        @(negedge clk);
        s_en = 1;
        wait_s_vs("s_f0_vs");
        // frame 0: solid A5C; switch to bars mid-frame (takes effect next frame)
        capture_frame(100, 2'd0, 0, len, lines, bad);
        check("s_f0_len", len, S_FRAME);
        check("s_f0_lines", lines, S_Y);
        check("s_f0_bad", bad, 0);
        check_px("s_f0_px_1_3", 3, 1, 16'h0A5C);
        check_px("s_f0_px_31_15", 15, 31, 16'h0A5C);
`ifdef CAM_STREAM_FRAMECNT_EN
        check_px("s_f0_px_0_0", 0, 0, 16'h0000);
`else
        check_px("s_f0_px_0_0", 0, 0, 16'h0A5C);
`endif
        @(negedge clk);
        check("s_b2b_vs1", s_cam.CAM_vsync, 1);
        // frame 1: colour bars; switch to checkerboard mid-frame
        capture_frame(100, 2'd3, 0, len, lines, bad);
        check("s_f1_len", len, S_FRAME);
        check("s_f1_bad", bad, 0);
        check_px("s_f1_px_4_0", 0, 4, 16'h0FF0);
        check_px("s_f1_px_13_2", 2, 13, 16'h00F0);
        check_px("s_f1_px_31_5", 5, 31, 16'h0000);
        check_px("s_f1_px_20_15", 15, 20, 16'h0F00);
`ifdef CAM_STREAM_FRAMECNT_EN
        check_px("s_f1_px_0_0", 0, 0, 16'h0001);
`else
        check_px("s_f1_px_0_0", 0, 0, 16'h0FFF);
`endif
        @(negedge clk);
        check("s_b2b_vs2", s_cam.CAM_vsync, 1);
        // frame 2: checkerboard; switch to gradient mid-frame
        capture_frame(100, 2'd2, 0, len, lines, bad);
        check("s_f2_len", len, S_FRAME);
        check("s_f2_bad", bad, 0);
        check_px("s_f2_px_8_8", 8, 8, 16'h0000);
        check_px("s_f2_px_0_8", 8, 0, 16'h0FFF);
        check_px("s_f2_px_8_0", 0, 8, 16'h0FFF);
        check_px("s_f2_px_7_7", 7, 7, 16'h0000);
`ifdef CAM_STREAM_FRAMECNT_EN
        check_px("s_f2_px_0_0", 0, 0, 16'h0002);
`else
        check_px("s_f2_px_0_0", 0, 0, 16'h0000);
`endif
        @(negedge clk);
        check("s_b2b_vs3", s_cam.CAM_vsync, 1);
        // frame 3: gradient; en dropped mid-ACTIVE, frame still completes
        capture_frame(0, 2'd0, 800, len, lines, bad);
        check("s_f3_len", len, S_FRAME);
        check("s_f3_lines", lines, S_Y);
        check("s_f3_bad", bad, 0);
        check_px("s_f3_px_31_15", 15, 31, 16'h0118);
        check_px("s_f3_px_5_2", 2, 5, 16'h0008);
`ifdef CAM_STREAM_FRAMECNT_EN
        check_px("s_f3_px_0_0", 0, 0, 16'h0003);
`else
        check_px("s_f3_px_0_0", 0, 0, 16'h0008);
`endif
        @(negedge clk);
        check("s_stop_busy", s_busy, 0);
        check("s_stop_vsync", s_cam.CAM_vsync, 0);
        repeat (200) @(negedge clk);
        check("s_idle_vsync", s_cam.CAM_vsync, 0);
        check("s_idle_busy", s_busy, 0);

        // mid-line reset, then a fresh full frame
        s_en = 1;
        wait_s_vs("s_rs_vs");
        repeat (450) @(negedge clk);
        check("s_rs_href", s_cam.CAM_href, 1);
        s_rst_n = 0;
        #1;
        check("s_rs_vsync0", s_cam.CAM_vsync, 0);
        check("s_rs_href0", s_cam.CAM_href, 0);
        check("s_rs_px0", s_cam.CAM_px_data, 0);
        check("s_rs_fd0", s_fd, 0);
        check("s_rs_busy0", s_busy, 0);
        @(negedge clk);
        s_rst_n = 1;
        wait_s_vs("s_f4_vs");
        capture_frame(0, 2'd0, 0, len, lines, bad);
        check("s_f4_len", len, S_FRAME);
        check("s_f4_lines", lines, S_Y);
        check("s_f4_bad", bad, 0);
`ifdef CAM_STREAM_FRAMECNT_EN
        check_px("s_f4_px_0_0", 0, 0, 16'h0000);
`else
        check_px("s_f4_px_0_0", 0, 0, 16'h0008);
`endif
        s_en = 0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
